reg_write_bank: RTL and testbench

Write side of the 32-entry x 32-bit register file. The read path selects from this block's flattened register outputs through the 32:1 read mux.
- Decodes a 5-bit write index to a one-hot enable and commits write data on the clock edge.
- Keeps register 0 hardwired to zero.
- Maintains a per-register busy scoreboard (claim on issue, release on writeback) for hazard detection upstream.

---
 rtl/reg_write_bank_pkg.sv | 9 +
 rtl/reg_write_bank_decoder_5to32.sv | 18 +
 rtl/reg_write_bank.sv | 82 ++++++++
 tb/tb_reg_write_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_write_bank_pkg.sv
// Shared sizing for the register-file write bank.
// Index width is tied to the 32-entry file.
package reg_write_bank_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 32;
    localparam int IDX_W    = 5;

    localparam logic [IDX_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_write_bank_decoder_5to32.sv
// Combinational 5-to-32 one-hot decoder with enable.
// Used for both the write strobe and the scoreboard claim.
module decoder_5to32
    import reg_write_bank_pkg::*;
(
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_bank.sv
// Write side of the 32x32 register file with busy scoreboard.
// Define REG_BYPASS_EN for write-through on regs_flat.
module reg_write_bank
    import reg_write_bank_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ctrl_writeEnable,
    input  logic [IDX_W-1:0]          ctrl_writeReg,
    input  logic [REG_W-1:0]          data_writeReg,
    input  logic                      claim_valid,
    input  logic [IDX_W-1:0]          claim_reg,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]       busy,
    output logic [NUM_REGS-1:0]       write_onehot,
    output logic                      write_ack
);

    logic [NUM_REGS-1:0] w_wr_oh;
    logic [NUM_REGS-1:0] w_claim_oh;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic [REG_W-1:0]    r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] r_wr_oh;
    logic                r_ack;

    decoder_5to32 u_wr_dec (
        .i_idx    (ctrl_writeReg),
        .i_en     (ctrl_writeEnable),
        .o_onehot (w_wr_oh)
    );

    decoder_5to32 u_claim_dec (
        .i_idx    (claim_reg),
        .i_en     (claim_valid),
        .o_onehot (w_claim_oh)
    );

    // A same-cycle claim outranks the retiring write; r0 never goes busy.
    always_comb begin
        w_busy_nxt = (r_busy & ~w_wr_oh) | w_claim_oh;
        w_busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy  <= '0;
            r_wr_oh <= '0;
            r_ack   <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_oh[i]) begin
                    r_regs[i] <= data_writeReg;
                end
            end
            r_busy  <= w_busy_nxt;
            r_wr_oh <= w_wr_oh;
            r_ack   <= ctrl_writeEnable;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_flat[i*REG_W +: REG_W] = r_regs[i];
`ifdef REG_BYPASS_EN
            if (w_wr_oh[i]) begin
                regs_flat[i*REG_W +: REG_W] = data_writeReg;
            end
`endif
        end
    end

    assign busy         = r_busy;
    assign write_onehot = r_wr_oh;
    assign write_ack    = r_ack;

endmodule

// File: tb/tb_reg_write_bank.sv
// Directed-vector bench for reg_write_bank.
// Inputs change and outputs are sampled on the falling edge.
module tb_reg_write_bank;
    import reg_write_bank_pkg::*;

    logic                      clock;
    logic                      reset;
    logic                      ctrl_writeEnable;
    logic [IDX_W-1:0]          ctrl_writeReg;
    logic [REG_W-1:0]          data_writeReg;
    logic                      claim_valid;
    logic [IDX_W-1:0]          claim_reg;
    logic [NUM_REGS*REG_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]       busy;
    logic [NUM_REGS-1:0]       write_onehot;
    logic                      write_ack;

    int n_vec;
    int n_err;

    reg_write_bank dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .claim_valid      (claim_valid),
        .claim_reg        (claim_reg),
        .regs_flat        (regs_flat),
        .busy             (busy),
        .write_onehot     (write_onehot),
        .write_ack        (write_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [NUM_REGS*REG_W-1:0] got,
                       input logic [NUM_REGS*REG_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REG_W-1:0] rd(input int i);
        return regs_flat[i*REG_W +: REG_W];
    endfunction

    task automatic drive(input logic we, input logic [IDX_W-1:0] wr,
                         input logic [REG_W-1:0] wd,
                         input logic cv, input logic [IDX_W-1:0] cr);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        claim_valid      = cv;
        claim_reg        = cr;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clock);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_regs", regs_flat, '0);
        chk("rst_busy", busy, '0);
        chk("rst_ack", write_ack, '0);
        chk("rst_oh", write_onehot, '0);

        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
`ifdef REG_BYPASS_EN
        chk("r5_bypass", rd(5), 32'hDEADBEEF);
`else
        chk("r5_pre", rd(5), 32'h0);
`endif
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("r5_data", rd(5), 32'hDEADBEEF);
        chk("r5_oh", write_onehot, 32'h00000020);
        chk("r5_ack", write_ack, 1'b1);
        tick();
        chk("idle_ack", write_ack, 1'b0);
        chk("idle_oh", write_onehot, '0);
        chk("r5_hold", rd(5), 32'hDEADBEEF);

        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
`ifdef REG_BYPASS_EN
        chk("r0_nobypass", rd(0), 32'h0);
`endif
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("r0_data", rd(0), 32'h0);
        chk("r0_ack", write_ack, 1'b1);
        chk("r0_oh", write_onehot, 32'h00000001);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick();
        chk("claim7", busy, 32'h00000080);
        drive(1'b1, 5'd7, 32'h00000077, 1'b1, 5'd7);
        tick();
        chk("wr_claim7", busy, 32'h00000080);
        chk("r7_data", rd(7), 32'h00000077);
        drive(1'b1, 5'd7, 32'h00000078, 1'b1, 5'd2);
        tick();
        chk("diff_idx", busy, 32'h00000004);
        drive(1'b1, 5'd6, 32'h00000066, 1'b1, 5'd2);
        tick();
        chk("reclaim2", busy, 32'h00000004);
        chk("r6_notbusy", rd(6), 32'h00000066);
        drive(1'b1, 5'd2, 32'h00000022, 1'b0, 5'd0);
        tick();
        chk("release2", busy, '0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        tick();
        chk("claim0", busy, '0);

        drive(1'b1, 5'd31, 32'h1, 1'b0, 5'd0);
        tick();
        chk("b2b_ack0", write_ack, 1'b1);
        chk("b2b_oh0", write_onehot, 32'h80000000);
        drive(1'b1, 5'd30, 32'h2, 1'b0, 5'd0);
        tick();
        chk("b2b_ack1", write_ack, 1'b1);
        chk("b2b_r31a", rd(31), 32'h1);
        drive(1'b1, 5'd31, 32'h3, 1'b0, 5'd0);
        tick();
        chk("b2b_ack2", write_ack, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("b2b_r30", rd(30), 32'h2);
        chk("b2b_r31", rd(31), 32'h3);
        tick();
        chk("b2b_ack_end", write_ack, 1'b0);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11);
        tick();
        chk("claim11", busy, 32'h00000800);
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd9);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("rst2_regs", regs_flat, '0);
        chk("rst2_busy", busy, '0);
        chk("rst2_ack", write_ack, 1'b0);
        chk("rst2_oh", write_onehot, '0);

        drive(1'b1, 5'd4, 32'hA5, 1'b0, 5'd0);
`ifdef REG_BYPASS_EN
        chk("r4_bypass", rd(4), 32'hA5);
        chk("r5_unaff", rd(5), 32'h0);
`else
        chk("r4_pre", rd(4), 32'h0);
`endif
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("r4_post", rd(4), 32'hA5);
        tick();
        chk("r4_hold", rd(4), 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
